mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_if.sv | 24 ++
 rtl/load_ext.sv | 28 ++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MIPS MEM stage.
// Access-type and exception codes, plus the store byte-enable mask.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_W  = 3'd0,
    MEM_H  = 3'd1,
    MEM_HU = 3'd2,
    MEM_B  = 3'd3,
    MEM_BU = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_RANGE    = 2'd2,
    EXC_RSVD     = 2'd3
  } exc_e;

  // Bytes touched by an access; byte 0 is bits 7:0 (little-endian).
  function automatic logic [3:0] be_mask(logic [2:0] op, logic [1:0] bsel);
    logic [3:0] be;
    be = 4'h0;
    case (op)
      MEM_W:         be = 4'hf;
      MEM_H, MEM_HU: be = bsel[1] ? 4'hc : 4'h3;
      MEM_B, MEM_BU: be = 4'h1 << bsel;
      default:       be = 4'h0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Request and MEM/WB result bundle between the pipeline and the MEM stage.
interface mem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mem_op;
  logic        mem_we;
  logic        mem_re;
  logic        stall;
  logic        flush;
  logic [31:0] rdata_wb;
  logic [31:0] addr_wb;
  logic        valid_wb;
  logic [1:0]  exc_wb;

  modport master (
    output addr, wdata, mem_op, mem_we, mem_re, stall, flush,
    input  rdata_wb, addr_wb, valid_wb, exc_wb
  );

  modport slave (
    input  addr, wdata, mem_op, mem_we, mem_re, stall, flush,
    output rdata_wb, addr_wb, valid_wb, exc_wb
  );
endinterface

// File: rtl/load_ext.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  bsel_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half   = bsel_i[1] ? word_i[31:16] : word_i[15:0];
    byte_v = word_i[8*bsel_i +: 8];
    data_o = '0;
    case (op_i)
      MEM_W:   data_o = word_i;
      MEM_H:   data_o = {{16{half[15]}}, half};
      MEM_HU:  data_o = {16'h0, half};
      MEM_B:   data_o = {{24{byte_v[7]}}, byte_v};
      MEM_BU:  data_o = {24'h0, byte_v};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory with byte/half/word access and the MEM/WB register.
// Loads read combinationally and register at the edge; stores commit at the same edge.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input logic  clk,
  input logic  rst_n,
  mem_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] SizeBytes = 33'(DEPTH) * 33'd4;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    bsel;
  logic          in_range;
  logic          misaligned;
  logic          rsvd;
  logic          wr_en;
  logic          ld_valid;
  exc_e          exc;
  logic [3:0]    be;
  logic [31:0]   wdata_al;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;

  logic [31:0]   rdata_wb_q, rdata_wb_d;
  logic [31:0]   addr_wb_q, addr_wb_d;
  logic          valid_wb_q, valid_wb_d;
  logic [1:0]    exc_wb_q, exc_wb_d;

  assign off      = bus.addr - ADDR_BASE;
  assign idx      = off[AW+1:2];
  assign bsel     = off[1:0];
  assign in_range = ({1'b0, off} < SizeBytes);
  assign rd_word  = mem_q[idx];
  assign be       = be_mask(bus.mem_op, bsel);

  always_comb begin
    misaligned = 1'b0;
    case (bus.mem_op)
      MEM_W:         misaligned = (bsel != 2'b00);
      MEM_H, MEM_HU: misaligned = bsel[0];
      default:       misaligned = 1'b0;
    endcase
  end

  // Unsigned variants only make sense for loads; storing with them is reserved.
  assign rsvd = (bus.mem_op > MEM_BU) ||
                (bus.mem_we && (bus.mem_op == MEM_HU || bus.mem_op == MEM_BU));

  always_comb begin
    exc = EXC_NONE;
    if (bus.mem_we || bus.mem_re) begin
      if (rsvd)           exc = EXC_RSVD;
      else if (!in_range) exc = EXC_RANGE;
      else if (misaligned) exc = EXC_MISALIGN;
    end
  end

  assign wr_en    = bus.mem_we && !bus.stall && !bus.flush && (exc == EXC_NONE);
  assign ld_valid = bus.mem_re && (exc == EXC_NONE);

  // Replicate store data so every byte lane carries the right value; be picks the lanes.
  always_comb begin
    wdata_al = '0;
    case (bus.mem_op)
      MEM_W:   wdata_al = bus.wdata;
      MEM_H:   wdata_al = {2{bus.wdata[15:0]}};
      default: wdata_al = {4{bus.wdata[7:0]}};
    endcase
  end

  load_ext u_load_ext (
    .word_i (rd_word),
    .bsel_i (bsel),
    .op_i   (bus.mem_op),
    .data_o (ext_data)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_d[idx][8*b +: 8] = wdata_al[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_wb_d = rdata_wb_q;
    addr_wb_d  = addr_wb_q;
    valid_wb_d = valid_wb_q;
    exc_wb_d   = exc_wb_q;
    if (bus.flush) begin
      rdata_wb_d = '0;
      addr_wb_d  = '0;
      valid_wb_d = 1'b0;
      exc_wb_d   = '0;
    end else if (!bus.stall) begin
      rdata_wb_d = ld_valid ? ext_data : '0;
      addr_wb_d  = bus.addr;
      valid_wb_d = ld_valid;
      exc_wb_d   = exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_wb_q <= '0;
      addr_wb_q  <= '0;
      valid_wb_q <= 1'b0;
      exc_wb_q   <= '0;
    end else begin
      rdata_wb_q <= rdata_wb_d;
      addr_wb_q  <= addr_wb_d;
      valid_wb_q <= valid_wb_d;
      exc_wb_q   <= exc_wb_d;
    end
  end

  assign bus.rdata_wb = rdata_wb_q;
  assign bus.addr_wb  = addr_wb_q;
  assign bus.valid_wb = valid_wb_q;
  assign bus.exc_wb   = exc_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage against a byte-array reference model.
module tb_mem_stage;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  mem_if bus ();

  mem_stage #(.DEPTH(DEPTH), .ADDR_BASE(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_rdata;
  logic [31:0] exp_addr;
  logic        exp_valid;
  logic [1:0]  exp_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rdata"}, bus.rdata_wb, exp_rdata);
    chk({tag, ".addr"}, bus.addr_wb, exp_addr);
    chk({tag, ".valid"}, 32'(bus.valid_wb), 32'(exp_valid));
    chk({tag, ".exc"}, 32'(bus.exc_wb), 32'(exp_exc));
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;
    exp_rdata = '0;
    exp_addr  = '0;
    exp_valid = 1'b0;
    exp_exc   = '0;
  endtask

  task automatic set_idle();
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.mem_op = '0;
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
  endtask

  // One clock: drive request, predict from the model, step the edge, check, then commit store.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input int op, input bit we, input bit re, input bit st, input bit fl);
    int          sz;
    int          e;
    bit          sgn;
    logic [31:0] ld;
    bus.addr   = a;
    bus.wdata  = wd;
    bus.mem_op = 3'(op);
    bus.mem_we = we;
    bus.mem_re = re;
    bus.stall  = st;
    bus.flush  = fl;
    sz  = (op == 0) ? 4 : (op <= 2) ? 2 : 1;
    sgn = (op == 1 || op == 3);
    e   = 0;
    if (we || re) begin
      if (op > 4 || (we && (op == 2 || op == 4))) e = 3;
      else if (a >= NBYTES) e = 2;
      else if ((a % sz) != 0) e = 1;
    end
    ld = '0;
    if (re && e == 0) begin
      for (int i = 0; i < sz; i++) ld |= 32'(ref_mem[int'(a) + i]) << (8 * i);
      if (sgn && ld[8*sz-1]) ld |= 32'hffff_ffff << (8 * sz);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      exp_rdata = '0;
      exp_addr  = '0;
      exp_valid = 1'b0;
      exp_exc   = '0;
    end else if (!st) begin
      exp_rdata = ld;
      exp_addr  = a;
      exp_valid = re && (e == 0);
      exp_exc   = 2'(e);
    end
    if (we && e == 0 && !st && !fl) begin
      for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
    end
    check_outputs(tag);
  endtask

  initial begin
    int op;
    logic [31:0] a;
    rst_n = 1'b0;
    set_idle();
    clear_model();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset");

    step("sw10", 32'h10, 32'h8badf00d, 0, 1, 0, 0, 0);
    step("lw10", 32'h10, 32'h0, 0, 0, 1, 0, 0);
    chk("lw10_const", bus.rdata_wb, 32'h8badf00d);
    step("sb13", 32'h13, 32'h0000_00ff, 3, 1, 0, 0, 0);
    step("lb13", 32'h13, 32'h0, 3, 0, 1, 0, 0);
    chk("lb13_const", bus.rdata_wb, 32'hffff_ffff);
    step("lbu13", 32'h13, 32'h0, 4, 0, 1, 0, 0);
    chk("lbu13_const", bus.rdata_wb, 32'h0000_00ff);
    step("lw10b", 32'h10, 32'h0, 0, 0, 1, 0, 0);
    chk("lw10_merge", bus.rdata_wb, 32'hffad_f00d);
    step("sh22", 32'h22, 32'h0000_8001, 1, 1, 0, 0, 0);
    step("lh22", 32'h22, 32'h0, 1, 0, 1, 0, 0);
    chk("lh22_const", bus.rdata_wb, 32'hffff_8001);
    step("lhu22", 32'h22, 32'h0, 2, 0, 1, 0, 0);
    chk("lhu22_const", bus.rdata_wb, 32'h0000_8001);
    step("sw11", 32'h11, 32'hdeadbeef, 0, 1, 0, 0, 0);
    chk("sw11_exc", 32'(bus.exc_wb), 32'd1);
    step("lw10c", 32'h10, 32'h0, 0, 0, 1, 0, 0);
    step("lh21", 32'h21, 32'h0, 1, 0, 1, 0, 0);
    chk("lh21_exc", 32'(bus.exc_wb), 32'd1);
    step("lw_oor", NBYTES, 32'h0, 0, 0, 1, 0, 0);
    chk("lw_oor_exc", 32'(bus.exc_wb), 32'd2);
    step("shu20", 32'h20, 32'h1234_5678, 2, 1, 0, 0, 0);
    step("lw20", 32'h20, 32'h0, 0, 0, 1, 0, 0);
    step("op6", 32'h20, 32'h0, 6, 0, 1, 0, 0);
    step("lw_stall", 32'h20, 32'h0, 0, 0, 1, 1, 0);
    step("sw_stall", 32'h30, 32'h5555_aaaa, 0, 1, 0, 1, 0);
    step("lw30", 32'h30, 32'h0, 0, 0, 1, 0, 0);
    step("swlw10", 32'h10, 32'h1234_5678, 0, 1, 1, 0, 0);
    chk("rbw_const", bus.rdata_wb, 32'hffad_f00d);
    step("lw10d", 32'h10, 32'h0, 0, 0, 1, 0, 0);
    step("flush_stall", 32'h10, 32'h0, 0, 0, 1, 1, 1);
    step("sw_flush", 32'h34, 32'h7777_7777, 0, 1, 0, 0, 1);
    step("lw34", 32'h34, 32'h0, 0, 0, 1, 0, 0);
    step("idle", 32'h44, 32'h0, 0, 0, 0, 0, 0);
    step("sw40", 32'h40, 32'hcafe_f00d, 0, 1, 0, 0, 0);

    // Asynchronous reset asserted between edges.
    #2;
    rst_n = 1'b0;
    #1;
    set_idle();
    clear_model();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_release");
    step("lw40", 32'h40, 32'h0, 0, 0, 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 15));
      step("rand", a, $urandom, op, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
